// File: rtl/fp_mul_pkg.sv
// Shared binary32 types and constants for the fp_mul datapath.
// Leading-zero count is used only when FP_MUL_SUBNORMAL_EN is defined.
package fp_mul_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    localparam int          EXP_BIAS = 127;
    localparam int          EXP_MAX  = 255;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF  = 32'h7F80_0000;

    function automatic logic [5:0] lzc48(input logic [47:0] v);
        logic [5:0] n;
        n = 6'd48;
        for (int i = 0; i < 48; i++) begin
            if (v[i]) n = 6'(47 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Normalize, RNE-round and range-check a 48-bit significand product.
// FP_MUL_SUBNORMAL_EN enables gradual underflow; otherwise tiny results flush.
module fp_mul_round
    import fp_mul_pkg::*;
(
    input  logic               sign_i,
    input  logic [47:0]        prod_i,
    input  logic signed [10:0] exp_i,
    output logic [31:0]        res_o
);

    logic [46:0]        frac;
    logic signed [10:0] exp_n;
    logic               sticky_x;
    logic               flush;

`ifdef FP_MUL_SUBNORMAL_EN
    logic [5:0]         lz;
    logic [47:0]        left;
    logic signed [10:0] exp_l;
    logic [10:0]        sh_raw;
    logic [5:0]         sh;
    logic [95:0]        wide;

    always_comb begin
        lz     = lzc48(prod_i);
        left   = prod_i << lz;
        exp_l  = exp_i + 11'sd1 - $signed({5'd0, lz});
        sh_raw = 11'sd1 - exp_l;
        if (exp_l > 11'sd0) begin
            sh = 6'd0;
        end else if (sh_raw > 11'd49) begin
            sh = 6'd49;
        end else begin
            sh = sh_raw[5:0];
        end
        // Denormalize: bits pushed below the LSB window feed sticky.
        wide     = {left, 48'd0} >> sh;
        frac     = wide[94:48];
        sticky_x = |wide[47:0];
        exp_n    = wide[95] ? exp_l : 11'sd0;
        flush    = 1'b0;
    end
`else
    always_comb begin
        frac     = prod_i[47] ? prod_i[46:0] : {prod_i[45:0], 1'b0};
        exp_n    = exp_i + $signed({10'd0, prod_i[47]});
        sticky_x = 1'b0;
        flush    = (exp_n <= 11'sd0);
    end
`endif

    logic [22:0] man;
    logic        g;
    logic        r;
    logic        s;
    logic        rnd;
    logic [30:0] sum;
    logic        ovf;

    // Carry out of the mantissa ripples into the exponent field, which
    // both renormalizes and promotes a subnormal to the minimum normal.
    always_comb begin
        man = frac[46:24];
        g   = frac[23];
        r   = frac[22];
        s   = (|frac[21:0]) | sticky_x;
        rnd = g & (r | s | frac[24]);
        sum = {exp_n[7:0], man} + {30'd0, rnd};
        ovf = (exp_n >= 11'sd255) | (&sum[30:23]);
        if (flush) begin
            res_o = {sign_i, 31'd0};
        end else if (ovf) begin
            res_o = {sign_i, 8'hFF, 23'd0};
        end else begin
            res_o = {sign_i, sum};
        end
    end

endmodule

// File: rtl/fp_mul.sv
// Single-cycle binary32 multiplier with registered output.
// FP_MUL_SUBNORMAL_EN enables subnormal inputs/outputs (default: flush to zero).
module fp_mul
    import fp_mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] IN1,
    input  logic [31:0] IN2,
    output logic        out_valid,
    output logic [31:0] OUT
);

    fp32_t a;
    fp32_t b;

    assign a = IN1;
    assign b = IN2;

    logic        a_nan;
    logic        b_nan;
    logic        a_inf;
    logic        b_inf;
    logic        a_zero;
    logic        b_zero;
    logic [23:0] sig_a;
    logic [23:0] sig_b;
    logic [7:0]  ea;
    logic [7:0]  eb;

    always_comb begin
        a_nan = (&a.exp) & (|a.man);
        b_nan = (&b.exp) & (|b.man);
        a_inf = (&a.exp) & ~(|a.man);
        b_inf = (&b.exp) & ~(|b.man);
`ifdef FP_MUL_SUBNORMAL_EN
        a_zero = ~(|a.exp) & ~(|a.man);
        b_zero = ~(|b.exp) & ~(|b.man);
        sig_a  = {|a.exp, a.man};
        sig_b  = {|b.exp, b.man};
        ea     = (|a.exp) ? a.exp : 8'd1;
        eb     = (|b.exp) ? b.exp : 8'd1;
`else
        a_zero = ~(|a.exp);
        b_zero = ~(|b.exp);
        sig_a  = {1'b1, a.man};
        sig_b  = {1'b1, b.man};
        ea     = a.exp;
        eb     = b.exp;
`endif
    end

    logic               sign;
    logic [47:0]        prod;
    logic signed [10:0] exp_sum;
    logic [31:0]        rnd_res;
    logic [31:0]        res_d;

    assign sign    = a.sign ^ b.sign;
    assign prod    = {24'd0, sig_a} * {24'd0, sig_b};
    assign exp_sum = $signed({3'b000, ea}) + $signed({3'b000, eb})
                   - 11'sd127;

    fp_mul_round u_round (
        .sign_i (sign),
        .prod_i (prod),
        .exp_i  (exp_sum),
        .res_o  (rnd_res)
    );

    always_comb begin
        if (a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf)) begin
            res_d = QNAN;
        end else if (a_inf | b_inf) begin
            res_d = POS_INF | {sign, 31'd0};
        end else if (a_zero | b_zero) begin
            res_d = {sign, 31'd0};
        end else begin
            res_d = rnd_res;
        end
    end

    logic [31:0] out_q;
    logic        vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 32'd0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) out_q <= res_d;
        end
    end

    assign OUT       = out_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_fp_mul.sv
// Randomized bench for fp_mul against an exact-arithmetic binary32 model.
// Honors FP_MUL_SUBNORMAL_EN the same way as the design.
module tb_fp_mul;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] IN1;
    logic [31:0] IN2;
    logic        out_valid;
    logic [31:0] OUT;

    int          total;
    int          bad;
    logic [31:0] exp_out;

    fp_mul dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .IN1       (IN1),
        .IN2       (IN2),
        .out_valid (out_valid),
        .OUT       (OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    // Exact product M*2^E, rounded to the binary32 grid with RNE.
    function automatic logic [31:0] ref_mul(input logic [31:0] x,
                                            input logic [31:0] y);
        logic        s;
        logic        xn, yn, xi, yi, xz, yz;
        logic [63:0] mx, my, m, quo, rem, half;
        int          ex, ey, e, msb, ue, q, sh, biased;
        s  = x[31] ^ y[31];
        xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
        yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
        xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
        yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
`ifdef FP_MUL_SUBNORMAL_EN
        xz = (x[30:0] == 0);
        yz = (y[30:0] == 0);
`else
        xz = (x[30:23] == 0);
        yz = (y[30:23] == 0);
`endif
        if (xn || yn || (xi && yz) || (xz && yi)) return 32'h7FC0_0000;
        if (xi || yi) return {s, 8'hFF, 23'd0};
        if (xz || yz) return {s, 31'd0};
        mx = {41'd0, (x[30:23] != 0), x[22:0]};
        my = {41'd0, (y[30:23] != 0), y[22:0]};
        ex = ((x[30:23] == 0) ? 1 : int'(x[30:23])) - 150;
        ey = ((y[30:23] == 0) ? 1 : int'(y[30:23])) - 150;
        m  = mx * my;
        e  = ex + ey;
        msb = 0;
        for (int i = 0; i < 64; i++) if (m[i]) msb = i;
        ue = msb + e;
        if (ue > 127) return {s, 8'hFF, 23'd0};
`ifndef FP_MUL_SUBNORMAL_EN
        if (ue < -126) return {s, 31'd0};
`endif
        q  = (ue < -126) ? -149 : ue - 23;
        sh = q - e;
        if (sh <= 0) begin
            quo = m << (-sh);
        end else if (sh > 60) begin
            quo = 64'd0;
        end else begin
            quo  = m >> sh;
            rem  = m - (quo << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && quo[0])) quo = quo + 1;
        end
        if (quo == (64'd1 << 24)) begin
            quo = 64'd1 << 23;
            q   = q + 1;
        end
        if (quo < (64'd1 << 23)) return {s, 8'd0, quo[22:0]};
        biased = q + 150;
        if (biased >= 255) return {s, 8'hFF, 23'd0};
        return {s, 8'(biased), quo[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] sp [9];
        logic [31:0] v;
        sp = '{32'h0, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
               32'h7FC0_0000, 32'h7F80_0001, 32'h0000_0001,
               32'h007F_FFFF, 32'h3F80_0000};
        v = $urandom;
        case ($urandom_range(0, 9))
            4: v[30:23] = 8'($urandom_range(0, 20));
            5: v[30:23] = 8'($urandom_range(230, 254));
            6: v = sp[$urandom_range(0, 8)];
            7: v[30:23] = 8'($urandom_range(100, 154));
            8, 9: v[30:23] = 8'($urandom_range(64, 190));
            default: ;
        endcase
        return v;
    endfunction

    // One clock: present operands, then check the registered output.
    task automatic cycle(input logic v, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] want,
                         input string tag);
        in_valid = v;
        IN1      = x;
        IN2      = y;
        @(posedge clk);
        #1;
        if (v) exp_out = want;
        check({tag, "_vld"}, {31'd0, out_valid}, {31'd0, v});
        check(tag, OUT, exp_out);
    endtask

    initial begin
        logic [31:0] x;
        logic [31:0] y;
        logic        v;
        total    = 0;
        bad      = 0;
        exp_out  = 32'd0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        IN1      = 32'd0;
        IN2      = 32'd0;
        #1;
        check("rst_out", OUT, 32'd0);
        check("rst_vld", {31'd0, out_valid}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        cycle(1, 32'hBF91EB85, 32'h75CABCBD, 32'hF5E71ED7, "big");
        cycle(1, 32'h3FC00000, 32'h3FC00000, 32'h40100000, "1p5sq");
        cycle(1, 32'h40000000, 32'h40000000, 32'h40800000, "2x2");
        cycle(0, 32'h12345678, 32'h9ABCDEF0, 32'd0, "hold");
        cycle(1, 32'h40000000, 32'h3F800000, 32'h40000000, "2x1");
        cycle(1, 32'h3F800000, 32'hBF800000, 32'hBF800000, "1xm1");
        cycle(1, 32'h40000000, 32'hBF800000, 32'hC0000000, "2xm1");
        cycle(1, 32'h7F800000, 32'h00000000, 32'h7FC00000, "infx0");
        cycle(1, 32'h00000000, 32'hFF800000, 32'h7FC00000, "0xinf");
        cycle(1, 32'h7FA00000, 32'h3F800000, 32'h7FC00000, "nan");
        cycle(1, 32'h80000000, 32'h3F800000, 32'h80000000, "negz");
        cycle(1, 32'hFF800000, 32'h40000000, 32'hFF800000, "ninf");
        cycle(1, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, "ovf");
`ifdef FP_MUL_SUBNORMAL_EN
        cycle(1, 32'h00800000, 32'h3F000000, 32'h00400000, "unf");
        cycle(1, 32'h00FFFFFF, 32'h3F000000, 32'h00800000, "unf_rup");
`else
        cycle(1, 32'h00800000, 32'h3F000000, 32'h00000000, "unf");
        cycle(1, 32'h00400000, 32'h3F800000, 32'h00000000, "sub_in");
`endif
        cycle(0, 32'h3F800000, 32'h3F800000, 32'd0, "idle");

        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 7) != 0);
            x = rnd_op();
            y = rnd_op();
            cycle(v, x, y, ref_mul(x, y), "rand");
        end

        cycle(1, 32'h40400000, 32'h40400000, 32'h41100000, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", OUT, 32'd0);
        check("mid_rst_vld", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("in_rst_out", OUT, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_out = 32'd0;
        cycle(1, 32'h40A00000, 32'h40000000, 32'h41200000, "post_rst");

        for (int i = 0; i < 100; i++) begin
            x = rnd_op();
            y = rnd_op();
            cycle(1, x, y, ref_mul(x, y), "b2b");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_mul.md
FP_MUL -- requirements
Module: fp_mul

Interface
REQ-001 Parameters: none; format fixed to IEEE-754 binary32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  IN1/IN2 hold a valid operand pair this cycle.
REQ-005 IN1  input  32  binary32 multiplicand.
REQ-006 IN2  input  32  binary32 multiplier.
REQ-007 out_valid  output  1  OUT holds a result this cycle.
REQ-008 OUT  output  32  binary32 product, registered.

Function
REQ-009 Latency SHALL be exactly 1 cycle: in_valid sampled at edge N gives out_valid=1 with the result after edge N.
REQ-010 Throughput SHALL be one operation per cycle; no backpressure.
REQ-011 When in_valid=0 at an edge, out_valid SHALL drop to 0 and OUT SHALL hold its previous value.
REQ-012 Sign SHALL be IN1[31] XOR IN2[31] for every non-NaN result, including zero and infinity.
REQ-013 Normal path: 24x24 significand product (hidden 1); exponent = eA+eB-127; normalize by 1 if product bit 47 set.
REQ-014 Rounding SHALL be round-to-nearest-even using guard, round and sticky (OR of all discarded bits).
REQ-015 A rounding carry-out of the significand SHALL increment the exponent and renormalize.
REQ-016 Biased exponent >=255 after rounding SHALL return signed infinity (exp 0xFF, mantissa 0).
REQ-017 Any NaN input SHALL return canonical qNaN 0x7FC00000.
REQ-018 Infinity times zero (either order) SHALL return 0x7FC00000.
REQ-019 Infinity times nonzero finite or infinity SHALL return signed infinity.
REQ-020 Zero times finite SHALL return signed zero.
REQ-021 Underflow handling SHALL follow REQ-026/REQ-027.

Reset
REQ-022 While rst_n=0: OUT=32'h0000_0000 and out_valid=0, asynchronously.
REQ-023 Reset asserted mid-operation SHALL discard the in-flight result; first result after release comes from the first in_valid edge after release.

Configuration
REQ-024 Macro FP_MUL_SUBNORMAL_EN selects subnormal support.
REQ-025 Both builds SHALL give identical results for all normal, zero, infinity and NaN cases that do not underflow.
REQ-026 With FP_MUL_SUBNORMAL_EN defined: subnormal inputs use hidden bit 0 and exponent 1; results below 2^-126 are right-shifted into subnormal form with sticky kept, then RNE-rounded; a round-up into 2^-126 SHALL yield the minimum normal.
REQ-027 Without the macro: subnormal inputs SHALL be treated as signed zero; results with biased exponent <=0 SHALL flush to signed zero.

Structure
REQ-028 Package fp_mul_pkg SHALL hold: binary32 packed struct typedef (sign, exp[7:0], man[22:0]), EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, POS_INF=32'h7F800000.
REQ-029 Sub-module fp_mul_round SHALL implement normalization, RNE rounding, overflow and underflow/subnormal handling as combinational logic; fp_mul holds operand decode, special-case detection, the significand multiply and the output register.

Verification
REQ-030 0xBF91EB85 x 0x75CABCBD (-1.14 x 5.14e32) -> 0xF5E71ED7 one cycle later.
REQ-031 0x3FC00000 x 0x3FC00000 (1.5 x 1.5) -> 0x40100000; 0x40000000 x 0x40000000 -> 0x40800000.
REQ-032 0x40000000 x 0x3F800000 -> 0x40000000; 0x3F800000 x 0xBF800000 -> 0xBF800000; 0x40000000 x 0xBF800000 -> 0xC0000000.
REQ-033 Specials: 0x7F800000 x 0x00000000 -> 0x7FC00000; 0x7FA00000 x 0x3F800000 -> 0x7FC00000; 0x80000000 x 0x3F800000 -> 0x80000000.
REQ-034 Overflow/underflow: 0x7F7FFFFF x 0x40000000 -> 0x7F800000; 0x00800000 x 0x3F000000 -> 0x00400000 with FP_MUL_SUBNORMAL_EN, 0x00000000 without.
REQ-035 Back-to-back in_valid for 3 cycles gives 3 consecutive out_valid results in order; rst_n pulsed low mid-stream forces OUT=0 and out_valid=0 immediately.
